// File: rtl/decode_pkg.sv
// Shared MIPS encodings for the decode stage: opcodes, functs, register
// indices, the NOP word and the instruction classifier.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd31;
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [3:0] {
    IC_ILLEGAL,
    IC_RTYPE,
    IC_JR,
    IC_JALR,
    IC_J,
    IC_JAL,
    IC_BRANCH,
    IC_ALU_IMM,
    IC_LOAD,
    IC_STORE
  } insn_class_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_imm;
    logic link;
    logic illegal;
  } ctrl_t;

  function automatic insn_class_e classify(input logic [5:0] op, input logic [5:0] funct);
    insn_class_e c;
    c = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_JR:   c = IC_JR;
          FN_JALR: c = IC_JALR;
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: c = IC_RTYPE;
          default: c = IC_ILLEGAL;
        endcase
      end
      OP_J:   c = IC_J;
      OP_JAL: c = IC_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c = IC_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c = IC_ALU_IMM;
      OP_LW:  c = IC_LOAD;
      OP_SW:  c = IC_STORE;
      default: c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero. Contents are deliberately not reset.
module decode_regfile #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  output logic [WORD_WIDTH-1:0]     rd_data_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic [WORD_WIDTH-1:0]     rd_data_b,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0]     wr_data
);

  logic [WORD_WIDTH-1:0] regs_q [2**REG_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/decode.sv
// MIPS instruction decode stage: register read with WB bypass, jump/branch
// resolution back to fetch, and the ID/EX pipeline register.
module decode
  import decode_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_WIDTH-1:0]     pc_id,
  input  logic [WORD_WIDTH-1:0]     ir_id,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [WORD_WIDTH-1:0]     wb_data,
  output logic                      jump,
  output logic [WORD_WIDTH-1:0]     target,
  output logic [WORD_WIDTH-1:0]     pc_ex,
  output logic [WORD_WIDTH-1:0]     rs_data_ex,
  output logic [WORD_WIDTH-1:0]     rt_data_ex,
  output logic [WORD_WIDTH-1:0]     imm_ex,
  output logic [REG_ADDR_WIDTH-1:0] dest_ex,
  output logic [4:0]                shamt_ex,
  output logic [5:0]                funct_ex,
  output logic [5:0]                opcode_ex,
  output logic                      reg_write_ex,
  output logic                      mem_read_ex,
  output logic                      mem_write_ex,
  output logic                      alu_imm_ex,
  output logic                      link_ex,
  output logic                      illegal_ex
);

  logic [5:0]                op;
  logic [5:0]                funct;
  logic [4:0]                shamt;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [15:0]               imm16;
  insn_class_e               iclass;

  assign op     = ir_id[31:26];
  assign rs     = ir_id[25:21];
  assign rt     = ir_id[20:16];
  assign rd     = ir_id[15:11];
  assign shamt  = ir_id[10:6];
  assign funct  = ir_id[5:0];
  assign imm16  = ir_id[15:0];
  assign iclass = classify(op, funct);

  logic [WORD_WIDTH-1:0] rf_rs;
  logic [WORD_WIDTH-1:0] rf_rt;

  decode_regfile #(
    .WORD_WIDTH    (WORD_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rd_addr_a(rs),
    .rd_data_a(rf_rs),
    .rd_addr_b(rt),
    .rd_data_b(rf_rt),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data)
  );

  // WB->ID bypass; r0 never bypasses so it always reads as zero.
  logic [WORD_WIDTH-1:0] rs_val;
  logic [WORD_WIDTH-1:0] rt_val;

  always_comb begin
    rs_val = rf_rs;
    rt_val = rf_rt;
    if (wb_en && (wb_addr == rs) && (rs != '0)) rs_val = wb_data;
    if (wb_en && (wb_addr == rt) && (rt != '0)) rt_val = wb_data;
  end

  logic [WORD_WIDTH-1:0] imm_sext;
  logic [WORD_WIDTH-1:0] imm_ext;

  assign imm_sext = {{(WORD_WIDTH-16){imm16[15]}}, imm16};

  always_comb begin
    imm_ext = imm_sext;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(WORD_WIDTH-16){1'b0}}, imm16};
      OP_LUI:                   imm_ext = {imm16, {(WORD_WIDTH-16){1'b0}}};
      default:                  imm_ext = imm_sext;
    endcase
  end

  logic branch_taken;

  always_comb begin
    branch_taken = 1'b0;
    case (op)
      OP_BEQ:  branch_taken = (rs_val == rt_val);
      OP_BNE:  branch_taken = (rs_val != rt_val);
      OP_BLEZ: branch_taken = ($signed(rs_val) <= 0);
      OP_BGTZ: branch_taken = ($signed(rs_val) > 0);
      default: branch_taken = 1'b0;
    endcase
  end

  logic jump_raw;

  always_comb begin
    jump_raw = 1'b0;
    target   = pc_id + imm_sext;
    case (iclass)
      IC_J, IC_JAL: begin
        jump_raw = 1'b1;
        target   = {pc_id[WORD_WIDTH-1:26], ir_id[25:0]};
      end
      IC_JR, IC_JALR: begin
        jump_raw = 1'b1;
        target   = rs_val;
      end
      IC_BRANCH: jump_raw = branch_taken;
      default:   jump_raw = 1'b0;
    endcase
  end

  assign jump = rst & jump_raw;

  ctrl_t                     ctrl;
  logic [REG_ADDR_WIDTH-1:0] dest;

  always_comb begin
    ctrl = '0;
    dest = REG_ADDR_WIDTH'(REG_ZERO);
    case (iclass)
      IC_RTYPE: begin
        ctrl.reg_write = 1'b1;
        dest           = rd;
      end
      IC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        dest           = rd;
      end
      IC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        dest           = REG_ADDR_WIDTH'(REG_RA);
      end
      IC_ALU_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
        dest           = rt;
      end
      IC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_imm   = 1'b1;
        dest           = rt;
      end
      IC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_imm   = 1'b1;
      end
      IC_JR, IC_J, IC_BRANCH: ctrl = '0;
      default: ctrl.illegal = 1'b1;
    endcase
    if (dest == '0) ctrl.reg_write = 1'b0;
  end

  logic [WORD_WIDTH-1:0]     pc_d, pc_q;
  logic [WORD_WIDTH-1:0]     rs_data_d, rs_data_q;
  logic [WORD_WIDTH-1:0]     rt_data_d, rt_data_q;
  logic [WORD_WIDTH-1:0]     imm_d, imm_q;
  logic [REG_ADDR_WIDTH-1:0] dest_d, dest_q;
  logic [4:0]                shamt_d, shamt_q;
  logic [5:0]                funct_d, funct_q;
  logic [5:0]                opcode_d, opcode_q;
  ctrl_t                     ctrl_d, ctrl_q;

  // Link instructions carry the return address past the delay slot.
  always_comb begin
    pc_d      = ctrl.link ? (pc_id + WORD_WIDTH'(1)) : pc_id;
    rs_data_d = rs_val;
    rt_data_d = rt_val;
    imm_d     = imm_ext;
    dest_d    = dest;
    shamt_d   = shamt;
    funct_d   = funct;
    opcode_d  = op;
    ctrl_d    = ctrl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      dest_q    <= '0;
      shamt_q   <= '0;
      funct_q   <= '0;
      opcode_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      dest_q    <= dest_d;
      shamt_q   <= shamt_d;
      funct_q   <= funct_d;
      opcode_q  <= opcode_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign pc_ex        = pc_q;
  assign rs_data_ex   = rs_data_q;
  assign rt_data_ex   = rt_data_q;
  assign imm_ex       = imm_q;
  assign dest_ex      = dest_q;
  assign shamt_ex     = shamt_q;
  assign funct_ex     = funct_q;
  assign opcode_ex    = opcode_q;
  assign reg_write_ex = ctrl_q.reg_write;
  assign mem_read_ex  = ctrl_q.mem_read;
  assign mem_write_ex = ctrl_q.mem_write;
  assign alu_imm_ex   = ctrl_q.alu_imm;
  assign link_ex      = ctrl_q.link;
  assign illegal_ex   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: reset behaviour, a table of hand-computed
// instruction vectors, and asynchronous reset in mid-stream.
module tb_decode;

  logic        clk;
  logic        rst;
  logic [31:0] pc_id;
  logic [31:0] ir_id;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump;
  logic [31:0] target;
  logic [31:0] pc_ex, rs_data_ex, rt_data_ex, imm_ex;
  logic [4:0]  dest_ex, shamt_ex;
  logic [5:0]  funct_ex, opcode_ex;
  logic        reg_write_ex, mem_read_ex, mem_write_ex, alu_imm_ex, link_ex, illegal_ex;

  int n_checks = 0;
  int n_fails  = 0;

  decode dut (
    .clk         (clk),
    .rst         (rst),
    .pc_id       (pc_id),
    .ir_id       (ir_id),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .jump        (jump),
    .target      (target),
    .pc_ex       (pc_ex),
    .rs_data_ex  (rs_data_ex),
    .rt_data_ex  (rt_data_ex),
    .imm_ex      (imm_ex),
    .dest_ex     (dest_ex),
    .shamt_ex    (shamt_ex),
    .funct_ex    (funct_ex),
    .opcode_ex   (opcode_ex),
    .reg_write_ex(reg_write_ex),
    .mem_read_ex (mem_read_ex),
    .mem_write_ex(mem_write_ex),
    .alu_imm_ex  (alu_imm_ex),
    .link_ex     (link_ex),
    .illegal_ex  (illegal_ex)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl packing: {reg_write, mem_read, mem_write, alu_imm, link, illegal}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RW   = 6'b100000;
  localparam logic [5:0] C_RWAI = 6'b100100;
  localparam logic [5:0] C_LINK = 6'b100010;
  localparam logic [5:0] C_LOAD = 6'b110100;
  localparam logic [5:0] C_STOR = 6'b001100;
  localparam logic [5:0] C_ILL  = 6'b000001;

  typedef struct {
    string       name;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        exp_jump;
    logic [31:0] exp_target;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_imm;
    logic [4:0]  exp_dest;
    logic [5:0]  exp_ctrl;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] dut_ctrl();
    return {reg_write_ex, mem_read_ex, mem_write_ex, alu_imm_ex, link_ex, illegal_ex};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".jump"},    {31'd0, jump}, 32'd0);
    check({tag, ".pc_ex"},   pc_ex,         32'd0);
    check({tag, ".rs_ex"},   rs_data_ex,    32'd0);
    check({tag, ".rt_ex"},   rt_data_ex,    32'd0);
    check({tag, ".imm_ex"},  imm_ex,        32'd0);
    check({tag, ".dest_ex"}, {27'd0, dest_ex}, 32'd0);
    check({tag, ".fields"},  {16'd0, shamt_ex, funct_ex, opcode_ex}, 32'd0);
    check({tag, ".ctrl"},    {26'd0, dut_ctrl()}, 32'd0);
  endtask

  task automatic add(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [31:0] pc, input logic [31:0] ir, input logic j, input logic [31:0] tgt,
                     input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                     input logic [4:0] dst, input logic [5:0] ctl, input logic [31:0] pcx);
    vec_t v;
    v.name = name; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.pc = pc; v.ir = ir;
    v.exp_jump = j; v.exp_target = tgt; v.exp_rs = rsv; v.exp_rt = rtv; v.exp_imm = imm;
    v.exp_dest = dst; v.exp_ctrl = ctl; v.exp_pc = pcx;
    vecs.push_back(v);
  endtask

  // Driver: inputs set just after an edge, combinational outputs checked
  // before the next edge, registered outputs checked just after it.
  task automatic apply(input vec_t v);
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data; pc_id = v.pc; ir_id = v.ir;
    #2;
    check({v.name, ".jump"}, {31'd0, jump}, {31'd0, v.exp_jump});
    if (v.exp_jump) check({v.name, ".target"}, target, v.exp_target);
    @(posedge clk);
    #1;
    check({v.name, ".rs_ex"},   rs_data_ex, v.exp_rs);
    check({v.name, ".rt_ex"},   rt_data_ex, v.exp_rt);
    check({v.name, ".imm_ex"},  imm_ex,     v.exp_imm);
    check({v.name, ".dest_ex"}, {27'd0, dest_ex}, {27'd0, v.exp_dest});
    check({v.name, ".ctrl"},    {26'd0, dut_ctrl()}, {26'd0, v.exp_ctrl});
    if (v.exp_ctrl[1]) check({v.name, ".pc_ex"}, pc_ex, v.exp_pc);
  endtask

  initial begin
    // Registers are preloaded to 0x1000_0000 + index before the table runs;
    // the table then overwrites r3, r1, r2 (twice) and r9 as noted.
    add("jr_bypass", 1, 5'd3, 32'hDEAD_BEEF, 32'h10, 32'h0060_0008, 1, 32'hDEAD_BEEF,
        32'hDEAD_BEEF, 32'h0, 32'h8, 5'd0, C_NONE, 32'h0);
    add("wr_r1", 1, 5'd1, 32'd7, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, C_NONE, 32'h0);
    add("wr_r2", 1, 5'd2, 32'd7, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, C_NONE, 32'h0);
    add("beq_taken", 0, 5'd0, 32'h0, 32'h100, 32'h1022_FFFC, 1, 32'hFC,
        32'd7, 32'd7, 32'hFFFF_FFFC, 5'd0, C_NONE, 32'h0);
    add("beq_not", 1, 5'd2, 32'd8, 32'h100, 32'h1022_FFFC, 0, 32'h0,
        32'd7, 32'd8, 32'hFFFF_FFFC, 5'd0, C_NONE, 32'h0);
    add("jal", 0, 5'd0, 32'h0, 32'h0400_0010, 32'h0C00_0020, 1, 32'h0400_0020,
        32'h0, 32'h0, 32'h20, 5'd31, C_LINK, 32'h0400_0011);
    add("lui", 0, 5'd0, 32'h0, 32'h0, 32'h3C01_1234, 0, 32'h0,
        32'h0, 32'd7, 32'h1234_0000, 5'd1, C_RWAI, 32'h0);
    add("ori", 0, 5'd0, 32'h0, 32'h0, 32'h3401_8000, 0, 32'h0,
        32'h0, 32'd7, 32'h0000_8000, 5'd1, C_RWAI, 32'h0);
    add("illegal_op", 0, 5'd0, 32'h0, 32'h0, 32'hFC00_0000, 0, 32'h0,
        32'h0, 32'h0, 32'h0, 5'd0, C_ILL, 32'h0);
    add("wr_r0", 1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0020, 0, 32'h0,
        32'h0, 32'h0, 32'h20, 5'd0, C_NONE, 32'h0);
    add("rd_r0", 0, 5'd0, 32'h0, 32'h0, 32'h0001_2020, 0, 32'h0,
        32'h0, 32'd7, 32'h2020, 5'd4, C_RW, 32'h0);
    add("addiu_neg", 0, 5'd0, 32'h0, 32'h0, 32'h2465_FFFF, 0, 32'h0,
        32'hDEAD_BEEF, 32'h1000_0005, 32'hFFFF_FFFF, 5'd5, C_RWAI, 32'h0);
    add("lw", 0, 5'd0, 32'h0, 32'h0, 32'h8C26_0004, 0, 32'h0,
        32'd7, 32'h1000_0006, 32'h4, 5'd6, C_LOAD, 32'h0);
    add("sw", 0, 5'd0, 32'h0, 32'h0, 32'hAC22_0008, 0, 32'h0,
        32'd7, 32'd8, 32'h8, 5'd0, C_STOR, 32'h0);
    add("bgtz_neg", 0, 5'd0, 32'h0, 32'h200, 32'h1C60_0010, 0, 32'h0,
        32'hDEAD_BEEF, 32'h0, 32'h10, 5'd0, C_NONE, 32'h0);
    add("blez_neg", 0, 5'd0, 32'h0, 32'h200, 32'h1860_0010, 1, 32'h210,
        32'hDEAD_BEEF, 32'h0, 32'h10, 5'd0, C_NONE, 32'h0);
    add("bgtz_pos", 0, 5'd0, 32'h0, 32'h600, 32'h1CA0_0001, 1, 32'h601,
        32'h1000_0005, 32'h0, 32'h1, 5'd0, C_NONE, 32'h0);
    add("bne_taken", 0, 5'd0, 32'h0, 32'h300, 32'h1422_0002, 1, 32'h302,
        32'd7, 32'd8, 32'h2, 5'd0, C_NONE, 32'h0);
    add("j_far", 0, 5'd0, 32'h0, 32'hF800_0000, 32'h0BFF_FFFF, 1, 32'hFBFF_FFFF,
        32'h1000_001F, 32'h1000_001F, 32'hFFFF_FFFF, 5'd0, C_NONE, 32'h0);
    add("jalr", 0, 5'd0, 32'h0, 32'h500, 32'h0020_3809, 1, 32'd7,
        32'd7, 32'h0, 32'h3809, 5'd7, C_LINK, 32'h501);
    add("bad_funct", 0, 5'd0, 32'h0, 32'h0, 32'h0000_003F, 0, 32'h0,
        32'h0, 32'h0, 32'h3F, 5'd0, C_ILL, 32'h0);
    add("blez_zero_bp", 1, 5'd9, 32'h0, 32'h400, 32'h1920_FFFF, 1, 32'h3FF,
        32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0, C_NONE, 32'h0);

    // Reset held low with ADDI r8, r0, 5 on the bus
    rst = 1'b0; pc_id = '0; ir_id = 32'h2008_0005; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    check_cleared("in_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("release.imm_ex",  imm_ex, 32'd5);
    check("release.dest_ex", {27'd0, dest_ex}, 32'd8);
    check("release.ctrl",    {26'd0, dut_ctrl()}, {26'd0, C_RWAI});
    check("release.rs_ex",   rs_data_ex, 32'd0);
    check("release.opcode",  {26'd0, opcode_ex}, 32'h08);

    // Preload the register file through the write-back port
    ir_id = 32'h0; pc_id = 32'h0;
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'h1000_0000 + 32'(i);
      @(posedge clk);
      #1;
    end
    wb_en = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset in mid-stream: JAL is registered, then reset is
    // asserted between edges and must clear everything at once.
    wb_en = 1'b0; pc_id = 32'h0400_0010; ir_id = 32'h0C00_0020;
    @(posedge clk);
    #1;
    check("pre_reset.link", {31'd0, link_ex}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_cleared("mid_reset");
    @(posedge clk);
    #1;
    check_cleared("held_reset");
    ir_id = 32'h3401_8000; pc_id = 32'h0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset.imm_ex",  imm_ex, 32'h0000_8000);
    check("after_reset.dest_ex", {27'd0, dest_ex}, 32'd1);
    check("after_reset.rt_ex",   rt_data_ex, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Instruction decode stage of the MIPS pipeline, placed directly after `fetch`. It takes the `pc_id`/`ir_id` pair from `fetch`, owns the 32×32 register file, and resolves all jumps and branches in ID, driving `jump`/`target` back to `fetch`. Each cycle it registers one decoded instruction (operands, extended immediate, destination, control bits) into the ID/EX pipeline register for the execute stage.

## Interface
- `WORD_WIDTH`, 32, datapath and PC width.
- `REG_ADDR_WIDTH`, 5, register index width (32 registers).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_id` in WORD_WIDTH: word address of the instruction on `ir_id`, plus one.
- `ir_id` in WORD_WIDTH: instruction word; all-zero is a NOP.
- `wb_en` in 1: register write-back enable.
- `wb_addr` in REG_ADDR_WIDTH: write-back register index.
- `wb_data` in WORD_WIDTH: write-back data.
- `jump` out 1: redirect `fetch` at the next edge (combinational).
- `target` out WORD_WIDTH: redirect word address (combinational).
- `pc_ex`, `rs_data_ex`, `rt_data_ex`, `imm_ex` out WORD_WIDTH: registered link value, operands and extended immediate.
- `dest_ex` out REG_ADDR_WIDTH: registered destination register.
- `shamt_ex` out 5; `funct_ex` out 6; `opcode_ex` out 6: registered instruction fields.
- `reg_write_ex`, `mem_read_ex`, `mem_write_ex`, `alu_imm_ex`, `link_ex`, `illegal_ex` out 1 each: registered control bits.

## Operation
- Fields: op=ir[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0], index=[25:0].
- Register file: 32 entries. r0 reads 0 and ignores writes. Contents are not reset. Writes occur at posedge when `wb_en` is high.
- Read bypass: if `wb_en` is high and `wb_addr` equals a nonzero read index, the read returns `wb_data` in the same cycle.
- Immediate: ANDI/ORI/XORI zero-extend. LUI gives {imm16, 16'h0}. All other opcodes sign-extend.
- Supported opcodes:
  - 00 R-type, including JR (funct 08) and JALR (09).
  - 02 J, 03 JAL.
  - 04 BEQ, 05 BNE, 06 BLEZ, 07 BGTZ.
  - 08–0F ALU-immediate.
  - 23 LW, 2B SW.
- Jump/branch resolution:
  - Uses bypassed register values with signed compares for BLEZ/BGTZ.
  - J/JAL: `target` = {pc_id[31:26], index}.
  - JR/JALR: `target` = rs value.
  - Taken branch: `target` = pc_id + sext(imm16), modulo 2^32.
  - `jump` is high only for a taken transfer. `target` is don't-care otherwise.
- Delay slot: one slot, architectural. The instruction after a jump is always executed. Decode does not guard a jump in a delay slot (undefined by ISA).
- Destination:
  - R-type → rd.
  - ALU-immediate and LW → rt.
  - JAL → 31.
  - JALR → rd.
- `reg_write_ex` is forced to 0 when the destination is 0.
- Link: `link_ex`=1 for JAL/JALR, with `pc_ex` = pc_id+1 (return address).
- Unknown opcode or funct: all control bits are 0 (bubble) and `illegal_ex`=1.
- Hazards: no interlock. Only WB→ID bypass is provided. Results from EX/MEM are not forwarded into branch compare; software schedules around this.

## Timing
- While `rst` is low:
  - All `*_ex` outputs are 0 (an `sll r0` NOP bubble).
  - `jump` is forced to 0.
- Reset assertion clears the ID/EX register immediately, including mid-operation. The first rising edge after release captures the current `ir_id`.
- `jump`/`target` are combinational from `ir_id` and `pc_id` in the same cycle. `fetch` loads `target` at the next edge.
- ID/EX latency: 1 cycle. Fields are valid the cycle after `ir_id` is presented.
- Write-back written at edge N is visible through the array from cycle N+1, and through the bypass in cycle N.

## Structure
- Shared header `mips_defs.vh`:
  - opcode and funct constants;
  - register index constants (ZERO=0, RA=31);
  - NOP encoding.
  It is used by decode, execute and any later stages.
- Sub-module `regfile`: two asynchronous read ports, one write port, r0 hardwired. The bypass lives in `decode`.

## Test plan
- Hold `rst` low with `ir_id`=0x2008_0005 → all `*_ex` are 0 and `jump`=0. Release → next edge: `imm_ex`=5, `dest_ex`=8, `reg_write_ex`=1, `alu_imm_ex`=1.
- `wb_en`=1, `wb_addr`=3, `wb_data`=0xDEAD_BEEF, with `ir_id`=0x0060_0008 (JR r3) the same cycle → `jump`=1, `target`=0xDEAD_BEEF.
- r1=r2=7 and `pc_id`=0x100, `ir_id`=0x1022_FFFC (BEQ -4) → `jump`=1, `target`=0xFC. Same with r2=8 → `jump`=0.
- `pc_id`=0x0400_0010, `ir_id`=0x0C00_0020 (JAL) → `target`=0x0400_0020; next edge: `dest_ex`=31, `link_ex`=1, `pc_ex`=0x0400_0011.
- `ir_id`=0x3C01_1234 (LUI) → `imm_ex`=0x1234_0000. `ir_id`=0x3401_8000 (ORI) → `imm_ex`=0x0000_8000. `ir_id`=0xFC00_0000 → `illegal_ex`=1 and all control bits 0.
- Write r0 with 0xFFFF_FFFF, then read it via an R-type instruction → `rs_data_ex`=0. Assert reset mid-stream → outputs clear without waiting for a clock edge.
